// File: rtl/dmem_access_unit_pkg.sv
// Shared memop codes and FSM state encoding for the data-memory access unit.
package dmem_access_unit_pkg;

  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LBU = 3'd1;
  localparam logic [2:0] MEM_LH  = 3'd2;
  localparam logic [2:0] MEM_LHU = 3'd3;
  localparam logic [2:0] MEM_LW  = 3'd4;
  localparam logic [2:0] MEM_SB  = 3'd5;
  localparam logic [2:0] MEM_SH  = 3'd6;
  localparam logic [2:0] MEM_SW  = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_access_unit_lane_align.sv
// Byte-lane aligner: store strobes and lane replication, load extraction and
// extension, and misalignment detection from memop and the low address bits.
module dmem_access_unit_lane_align
  import dmem_access_unit_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata_ext,
  output logic        o_mis
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_wstrb     = 4'b0000;
    o_wdata_rep = i_wdata;
    o_rdata_ext = i_rdata;
    o_mis       = 1'b0;
    case (i_memop)
      MEM_LB:  o_rdata_ext = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_rdata_ext = {24'd0, w_byte};
      MEM_LH: begin
        o_rdata_ext = {{16{w_half[15]}}, w_half};
        o_mis       = i_addr_lo[0];
      end
      MEM_LHU: begin
        o_rdata_ext = {16'd0, w_half};
        o_mis       = i_addr_lo[0];
      end
      MEM_LW:  o_mis = (i_addr_lo != 2'd0);
      MEM_SB: begin
        o_wstrb     = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
      end
      MEM_SH: begin
        o_wstrb     = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_mis       = i_addr_lo[0];
      end
      MEM_SW: begin
        o_wstrb = 4'b1111;
        o_mis   = (i_addr_lo != 2'd0);
      end
      default: o_mis = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus master with timeout, lane
// alignment, address-error flags and a pipeline stall while an access is in flight.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [2:0]  memopM,
  input  logic        flushM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic [31:0] rdataM,
  output logic        mem_stall,
  output logic        adelM,
  output logic        adesM,
  output logic        bus_errM,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_req;
  logic             r_bus_wr;
  logic [31:0]      r_bus_addr;
  logic [3:0]       r_bus_wstrb;
  logic [31:0]      r_bus_wdata;
  logic [31:0]      r_rdata;
  logic             r_bus_err;

  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata_rep;
  logic [31:0]      w_rdata_ext;
  logic             w_mis;
  logic             w_start;
  logic             w_timeout;

  dmem_access_unit_lane_align u_lane_align (
    .i_memop     (memopM),
    .i_addr_lo   (addrM[1:0]),
    .i_wdata     (wdataM),
    .i_rdata     (bus_rdata),
    .o_wstrb     (w_wstrb),
    .o_wdata_rep (w_wdata_rep),
    .o_rdata_ext (w_rdata_ext),
    .o_mis       (w_mis)
  );

  assign adelM     = memenM & ~memwriteM & w_mis;
  assign adesM     = memenM & memwriteM & w_mis;
  assign w_start   = memenM & ~w_mis & ~flushM;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // flushM is only honoured in IDLE; once on the bus the access must finish.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_next = StReq;
      StReq:   if (bus_ack || w_timeout) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    case (r_state)
      StIdle:  mem_stall = w_start;
      StReq:   mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Load data is extended at capture time, so rdataM is a plain register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wstrb <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_bus_req   <= 1'b1;
            r_bus_wr    <= memwriteM;
            r_bus_addr  <= {addrM[31:2], 2'b00};
            r_bus_wstrb <= w_wstrb;
            r_bus_wdata <= w_wdata_rep;
            r_cnt       <= '0;
          end
        end
        StReq: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            r_bus_wr  <= 1'b0;
            r_rdata   <= w_rdata_ext;
            r_bus_err <= 1'b0;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_bus_wr  <= 1'b0;
            r_rdata   <= '0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StDone:  r_bus_err <= 1'b0;
        default: r_bus_err <= 1'b0;
      endcase
    end
  end

  assign rdataM    = r_rdata;
  assign bus_errM  = r_bus_err;
  assign bus_req   = r_bus_req;
  assign bus_wr    = r_bus_wr;
  assign bus_addr  = r_bus_addr;
  assign bus_wstrb = r_bus_wstrb;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed, table-driven bench for dmem_access_unit with a few hand-written
// multi-cycle sequences (flush during REQ, reset during REQ).
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, flushM;
  logic [2:0]  memopM;
  logic [31:0] addrM, wdataM, rdataM;
  logic        mem_stall, adelM, adesM, bus_errM;
  logic        bus_req, bus_wr, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .memenM    (memenM),
    .memwriteM (memwriteM),
    .memopM    (memopM),
    .flushM    (flushM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .rdataM    (rdataM),
    .mem_stall (mem_stall),
    .adelM     (adelM),
    .adesM     (adesM),
    .bus_errM  (bus_errM),
    .bus_req   (bus_req),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  typedef struct {
    logic [2:0]  op;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        flush;      // flushM from the first (IDLE) cycle
    logic        flush_req;  // flushM raised once the access is in REQ
    int          ack_dly;    // REQ cycles without ack before ack; large = never
    logic [31:0] rd_in;
    int          e_stall;
    int          e_req;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_addr;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_adel;
    logic        e_ades;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          stall_n = 0;
    int          req_n   = 0;
    logic        got_req = 1'b0;
    logic        done    = 1'b0;
    logic [3:0]  strb    = '0;
    logic [31:0] wdv     = '0;
    logic [31:0] av      = '0;
    logic        wrv     = 1'b0;
    logic        adel_s  = 1'b0;
    logic        ades_s  = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        memenM    = 1'b1;
        memwriteM = v.wr;
        memopM    = v.op;
        addrM     = v.addr;
        wdataM    = v.wd;
        flushM    = v.flush;
        bus_rdata = v.rd_in;
      end
      if (k == 1 && v.flush_req) flushM = 1'b1;
      bus_ack = 1'b0;
      #1;
      if (k == 0) begin
        adel_s = adelM;
        ades_s = adesM;
      end
      if (mem_stall) stall_n++;
      if (bus_req) begin
        if (!got_req) begin
          strb = bus_wstrb;
          wdv  = bus_wdata;
          av   = bus_addr;
          wrv  = bus_wr;
        end
        got_req = 1'b1;
        if (req_n == v.ack_dly) bus_ack = 1'b1;
        req_n++;
      end else if (!mem_stall) begin
        done = 1'b1;
        if (k > 0) begin
          if (!v.wr) chk($sformatf("v%0d rdataM", idx), rdataM, v.e_rdata);
          chk($sformatf("v%0d bus_errM", idx), {31'd0, bus_errM}, {31'd0, v.e_err});
        end
      end
    end
    chk($sformatf("v%0d reached_done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d stall_cycles", idx), stall_n, v.e_stall);
    chk($sformatf("v%0d req_cycles", idx), req_n, v.e_req);
    chk($sformatf("v%0d adelM", idx), {31'd0, adel_s}, {31'd0, v.e_adel});
    chk($sformatf("v%0d adesM", idx), {31'd0, ades_s}, {31'd0, v.e_ades});
    if (v.e_req > 0) begin
      chk($sformatf("v%0d bus_wstrb", idx), {28'd0, strb}, {28'd0, v.e_strb});
      chk($sformatf("v%0d bus_addr", idx), av, v.e_addr);
      chk($sformatf("v%0d bus_wr", idx), {31'd0, wrv}, {31'd0, v.wr});
      if (v.wr) chk($sformatf("v%0d bus_wdata", idx), wdv, v.e_wdata);
    end
    memenM  = 1'b0;
    flushM  = 1'b0;
    bus_ack = 1'b0;
    @(negedge clk);
    #1;
    chk($sformatf("v%0d idle_err_clear", idx), {31'd0, bus_errM}, 32'd0);
    chk($sformatf("v%0d idle_req_low", idx), {31'd0, bus_req}, 32'd0);
  endtask

  vec_t vecs [15];
  vec_t post_rst;

  initial begin
    //          op       wr addr          wd            fl fr ack rd_in         stl req strb   e_wdata       e_addr        e_rdata       err adl ads
    vecs[0]  = '{MEM_SW,  1, 32'h100, 32'h11223344, 0, 0, 0,  32'h0,        2,  1, 4'hF, 32'h11223344, 32'h100, 32'h0,        0, 0, 0};
    vecs[1]  = '{MEM_LB,  0, 32'h103, 32'h0,        0, 0, 0,  32'h80FFFFFF, 2,  1, 4'h0, 32'h0,        32'h100, 32'hFFFFFF80, 0, 0, 0};
    vecs[2]  = '{MEM_LBU, 0, 32'h103, 32'h0,        0, 0, 0,  32'h80FFFFFF, 2,  1, 4'h0, 32'h0,        32'h100, 32'h00000080, 0, 0, 0};
    vecs[3]  = '{MEM_SH,  1, 32'h102, 32'h0000BEEF, 0, 0, 1,  32'h0,        3,  2, 4'hC, 32'hBEEFBEEF, 32'h100, 32'h0,        0, 0, 0};
    vecs[4]  = '{MEM_LH,  0, 32'h101, 32'h0,        0, 0, 0,  32'h0,        0,  0, 4'h0, 32'h0,        32'h0,   32'h0,        0, 1, 0};
    vecs[5]  = '{MEM_LW,  0, 32'h200, 32'h0,        0, 0, 99, 32'hFFFFFFFF, 17, 16, 4'h0, 32'h0,       32'h200, 32'h0,        1, 0, 0};
    vecs[6]  = '{MEM_SW,  1, 32'h104, 32'h55AA55AA, 1, 0, 0,  32'h0,        0,  0, 4'h0, 32'h0,        32'h0,   32'h0,        0, 0, 0};
    vecs[7]  = '{MEM_LHU, 0, 32'h106, 32'h0,        0, 0, 2,  32'h80011234, 4,  3, 4'h0, 32'h0,        32'h104, 32'h00008001, 0, 0, 0};
    vecs[8]  = '{MEM_LH,  0, 32'h106, 32'h0,        0, 0, 0,  32'h80011234, 2,  1, 4'h0, 32'h0,        32'h104, 32'hFFFF8001, 0, 0, 0};
    vecs[9]  = '{MEM_LW,  0, 32'h108, 32'h0,        0, 0, 0,  32'hDEADBEEF, 2,  1, 4'h0, 32'h0,        32'h108, 32'hDEADBEEF, 0, 0, 0};
    vecs[10] = '{MEM_SB,  1, 32'h10A, 32'h000000A5, 0, 0, 0,  32'h0,        2,  1, 4'h4, 32'hA5A5A5A5, 32'h108, 32'h0,        0, 0, 0};
    vecs[11] = '{MEM_SW,  1, 32'h10B, 32'h12345678, 0, 0, 0,  32'h0,        0,  0, 4'h0, 32'h0,        32'h0,   32'h0,        0, 0, 1};
    vecs[12] = '{MEM_LB,  0, 32'h101, 32'h0,        0, 0, 0,  32'h00007F00, 2,  1, 4'h0, 32'h0,        32'h100, 32'h0000007F, 0, 0, 0};
    vecs[13] = '{MEM_LW,  0, 32'h10C, 32'h0,        0, 0, 15, 32'h12345678, 17, 16, 4'h0, 32'h0,       32'h10C, 32'h12345678, 0, 0, 0};
    vecs[14] = '{MEM_SW,  1, 32'h110, 32'hCAFEF00D, 0, 1, 1,  32'h0,        3,  2, 4'hF, 32'hCAFEF00D, 32'h110, 32'h0,        0, 0, 0};
    post_rst = '{MEM_LW,  0, 32'h404, 32'h0,        0, 0, 0,  32'h0BADF00D, 2,  1, 4'h0, 32'h0,        32'h404, 32'h0BADF00D, 0, 0, 0};

    rst       = 1'b0;
    memenM    = 1'b0;
    memwriteM = 1'b0;
    memopM    = MEM_LW;
    flushM    = 1'b0;
    addrM     = '0;
    wdataM    = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset bus_req",   {31'd0, bus_req},   32'd0);
    chk("reset bus_wr",    {31'd0, bus_wr},    32'd0);
    chk("reset bus_addr",  bus_addr,           32'd0);
    chk("reset bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("reset bus_wdata", bus_wdata,          32'd0);
    chk("reset rdataM",    rdataM,             32'd0);
    chk("reset bus_errM",  {31'd0, bus_errM},  32'd0);
    chk("reset mem_stall", {31'd0, mem_stall}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Reset asserted while the access sits in REQ waiting for ack.
    @(negedge clk);
    memenM    = 1'b1;
    memwriteM = 1'b0;
    memopM    = MEM_LW;
    addrM     = 32'h400;
    flushM    = 1'b0;
    bus_ack   = 1'b0;
    @(negedge clk);
    #1;
    chk("midreq bus_req_up", {31'd0, bus_req}, 32'd1);
    rst    = 1'b0;
    memenM = 1'b0;
    #1;
    chk("midreq bus_req_drop", {31'd0, bus_req},   32'd0);
    chk("midreq stall_drop",   {31'd0, mem_stall}, 32'd0);
    chk("midreq bus_addr_clr", bus_addr,           32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(15, post_rst);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
